rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//   Shares the register file's single synchronous write port between two writeback requesters: A (execute/ALU) and B (load unit).
//   Round-robin arbitration with valid/ready handshakes. Holds a per-register busy scoreboard so decode can detect RAW hazards.
//   Sits between the execute/load stages and rf; its o_rd_* outputs drive rf's i_rd_* inputs directly.
// PARAMETERS
//   BYPASS_EN  0  1: a commit this cycle masks the busy bit of the same address on the query ports (match rf setting)
// PORTS
//   i_clk         in   1   global clock
//   i_rst_n       in   1   asynchronous active-low reset
//   i_a_valid     in   1   requester A has a write pending
//   i_a_waddr     in   5   A destination register
//   i_a_wdata     in   32  A write data
//   o_a_ready     out  1   A write accepted this cycle
//   i_b_valid     in   1   requester B has a write pending
//   i_b_waddr     in   5   B destination register
//   i_b_wdata     in   32  B write data
//   o_b_ready     out  1   B write accepted this cycle
//   i_wb_hold     in   1   blocks all grants while high
//   o_rd_wen      out  1   to rf write enable
//   o_rd_waddr    out  5   to rf write address
//   o_rd_wdata    out  32  to rf write data
//   i_rsv_en      in   1   reserve a destination at issue
//   i_rsv_addr    in   5   register to reserve
//   i_rs1_raddr   in   5   hazard query 1
//   o_rs1_busy    out  1   query 1 has a pending write
//   i_rs2_raddr   in   5   hazard query 2
//   o_rs2_busy    out  1   query 2 has a pending write
//   o_stall_cnt   out  32  contention statistic (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (i_rst_n low, async): rr_ptr=A, all busy bits 0, stall count 0. While in reset: readys=0, o_rd_wen=0, busys=0.
//   - Grant is combinational, zero latency. A transfer completes on a cycle where valid && ready.
//   - Only one requester valid: it is granted.
//   - Both valid: the requester named by rr_ptr is granted. The other waits, so its worst-case wait is 1 cycle.
//   - Grant to X: rr_ptr <= other(X) at the next edge. rr_ptr holds when nothing is granted.
//   - i_wb_hold=1: no grant, readys=0, o_rd_wen=0, rr_ptr holds.
//   - Requesters must hold valid/addr/data stable until ready. Ready may depend on valid (no comb path from ready to valid).
//   - o_rd_waddr/o_rd_wdata are the granted requester's fields. They are 0 when there is no grant.
//   - o_rd_wen = grant && waddr!=0.
//   - A write to x0 is still accepted (ready=1), but rf is not written and the scoreboard is untouched.
//   - Scoreboard: busy[31:1] registers; busy[0] is constant 0.
//     - i_rsv_en with addr!=0 sets busy[addr] at the next edge.
//     - A commit with o_rd_wen clears busy[waddr] at the next edge.
//     - Reserve and commit to the same address in the same cycle: the set wins (a new producer is in flight).
//     - Reserving an already-busy register is legal; the bit stays 1. The first commit clears it; producers to one register must commit in order.
//   - o_rsN_busy = busy[i_rsN_raddr], combinational.
//     - BYPASS_EN=1: forced 0 when o_rd_wen && o_rd_waddr==i_rsN_raddr in the same cycle.
//     - BYPASS_EN=0: stays 1 until the edge after the commit.
// CONFIGURATION
//   RF_WB_ARB_STATS_EN defined:
//     - o_stall_cnt counts cycles where some valid requester was not granted, including hold cycles.
//     - +1 per cycle, saturates at 32'hFFFF_FFFF, async-cleared by reset.
//   RF_WB_ARB_STATS_EN undefined: o_stall_cnt tied to 32'h0 and no counter logic is generated. The port always exists.
// STRUCTURE
//   - Package rf_wb_pkg: XLEN=32, REG_AW=5, NUM_REGS=32, typedef enum logic {REQ_A, REQ_B} req_id_t (rr_ptr type).
//   - Sub-module rf_scoreboard: busy bit array, set/clear priority, two query ports, BYPASS_EN mask.
//   - The arbiter and the stats counter stay in the top module.
// TESTING
//   1 Reset: i_rst_n low with both valid=1 -> readys=0, o_rd_wen=0. Release, both valid -> A granted first.
//   2 Contention: A(x5,32'h11) and B(x6,32'h22) both valid for 2 cycles.
//     -> cycle 0: A written, B waits. cycle 1: B written. rr_ptr=A afterwards.
//     -> stats on: o_stall_cnt=1.
//   3 x0: B valid, waddr=0, wdata=32'hDEAD -> o_b_ready=1, o_rd_wen=0, busy bits unchanged.
//   4 Scoreboard: reserve x7; next cycle query x7 -> busy=1.
//     -> A commits x7: BYPASS_EN=0 busy=1 that cycle, 0 next; BYPASS_EN=1 busy=0 that cycle.
//   5 Same-cycle reserve x9 and commit x9 -> busy[9]=1 afterwards.
//   6 i_wb_hold=1 for 3 cycles with A valid -> no write, rr_ptr unchanged; stats on: o_stall_cnt +=3.
//     -> assert i_rst_n low mid-hold: all busy bits clear immediately.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared types and sizes for the register-file writeback arbiter slice.
package rf_wb_pkg;

  localparam int unsigned XLEN     = 32'd32;
  localparam int unsigned REG_AW   = 32'd5;
  localparam int unsigned NUM_REGS = 32'd32;

  // Identifies a writeback requester; also the type of the round-robin pointer.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // The requester that gets priority after the given one has been served.
  function automatic req_id_t other_req(input req_id_t id);
    case (id)
      REQ_A:   return REQ_B;
      REQ_B:   return REQ_A;
      default: return REQ_A;
    endcase
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for RAW hazard detection. Register 0 is never busy.
// A reservation and a commit to the same register in one cycle leaves the bit
// set, because the reservation belongs to a newer producer. With BYPASS_EN the
// query ports report a register as free in the very cycle its commit happens.
module rf_scoreboard
  import rf_wb_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] q1_addr,
  output logic              q1_busy,
  input  logic [REG_AW-1:0] q2_addr,
  output logic              q2_busy
);

  logic [NUM_REGS-1:1] busy_r;
  logic [NUM_REGS-1:1] set_mask_s;
  logic [NUM_REGS-1:1] clr_mask_s;
  logic [NUM_REGS-1:1] busy_next_s;
  logic [NUM_REGS-1:0] busy_vec_s;

  assign busy_vec_s = {busy_r, 1'b0};

  // Decode set/clear requests into one-hot masks; set is applied after clear so it wins.
  always_comb begin
    set_mask_s = {(NUM_REGS-1){1'b0}};
    clr_mask_s = {(NUM_REGS-1){1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      set_mask_s[i] = set_en && (set_addr == REG_AW'(i));
      clr_mask_s[i] = clr_en && (clr_addr == REG_AW'(i));
    end
    busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
  end

  // Busy bit storage, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {(NUM_REGS-1){1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign q1_busy = busy_vec_s[q1_addr] & ~(BYPASS_EN & clr_en & (clr_addr == q1_addr));
  assign q2_busy = busy_vec_s[q2_addr] & ~(BYPASS_EN & clr_en & (clr_addr == q2_addr));

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the
// execute unit (A) and the load unit (B), plus the busy scoreboard.
// Optional feature: define RF_WB_ARB_STATS_EN to build the saturating
// contention counter on o_stall_cnt; otherwise the port is tied to zero.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_valid,
  input  logic [REG_AW-1:0] i_a_waddr,
  input  logic [XLEN-1:0]   i_a_wdata,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [REG_AW-1:0] i_b_waddr,
  input  logic [XLEN-1:0]   i_b_wdata,
  output logic              o_b_ready,
  input  logic              i_wb_hold,
  output logic              o_rd_wen,
  output logic [REG_AW-1:0] o_rd_waddr,
  output logic [XLEN-1:0]   o_rd_wdata,
  input  logic              i_rsv_en,
  input  logic [REG_AW-1:0] i_rsv_addr,
  input  logic [REG_AW-1:0] i_rs1_raddr,
  output logic              o_rs1_busy,
  input  logic [REG_AW-1:0] i_rs2_raddr,
  output logic              o_rs2_busy,
  output logic [XLEN-1:0]   o_stall_cnt
);

  req_id_t rr_ptr_r;
  req_id_t rr_ptr_next_s;
  logic    grant_en_s;
  logic    a_grant_s;
  logic    b_grant_s;
  logic    any_grant_s;

  // Grants are suppressed during reset as well as while writeback is held.
  assign grant_en_s  = i_rst_n & ~i_wb_hold;
  assign any_grant_s = a_grant_s | b_grant_s;

  // Round-robin pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_r <= REQ_A;
    end else begin
      rr_ptr_r <= rr_ptr_next_s;
    end
  end

  // Pointer moves past whoever was served; holds when nobody was.
  always_comb begin
    rr_ptr_next_s = rr_ptr_r;
    if (a_grant_s) begin
      rr_ptr_next_s = other_req(REQ_A);
    end else if (b_grant_s) begin
      rr_ptr_next_s = other_req(REQ_B);
    end else begin
      rr_ptr_next_s = rr_ptr_r;
    end
  end

  // Zero-latency grant decision and write-port mux.
  always_comb begin
    a_grant_s  = 1'b0;
    b_grant_s  = 1'b0;
    o_rd_waddr = {REG_AW{1'b0}};
    o_rd_wdata = {XLEN{1'b0}};
    if (!grant_en_s) begin
      a_grant_s = 1'b0;
      b_grant_s = 1'b0;
    end else if (i_a_valid && i_b_valid) begin
      a_grant_s = (rr_ptr_r == REQ_A);
      b_grant_s = (rr_ptr_r == REQ_B);
    end else begin
      a_grant_s = i_a_valid;
      b_grant_s = i_b_valid;
    end
    if (a_grant_s) begin
      o_rd_waddr = i_a_waddr;
      o_rd_wdata = i_a_wdata;
    end else if (b_grant_s) begin
      o_rd_waddr = i_b_waddr;
      o_rd_wdata = i_b_wdata;
    end else begin
      o_rd_waddr = {REG_AW{1'b0}};
      o_rd_wdata = {XLEN{1'b0}};
    end
    o_a_ready = a_grant_s;
    o_b_ready = b_grant_s;
    // x0 writes complete the handshake but never reach the register file.
    o_rd_wen  = any_grant_s && (o_rd_waddr != {REG_AW{1'b0}});
  end

  rf_scoreboard #(
    .BYPASS_EN (BYPASS_EN)
  ) u_scoreboard (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .set_en   (i_rsv_en),
    .set_addr (i_rsv_addr),
    .clr_en   (o_rd_wen),
    .clr_addr (o_rd_waddr),
    .q1_addr  (i_rs1_raddr),
    .q1_busy  (o_rs1_busy),
    .q2_addr  (i_rs2_raddr),
    .q2_busy  (o_rs2_busy)
  );

`ifdef RF_WB_ARB_STATS_EN
  logic [XLEN-1:0] stall_cnt_r;
  logic            stall_s;

  // A cycle counts as contention when any valid requester was left waiting.
  assign stall_s = (i_a_valid & ~a_grant_s) | (i_b_valid & ~b_grant_s);

  // Saturating contention counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_r <= 32'h0;
    end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'h1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_stall_cnt = stall_cnt_r;
`else
  assign o_stall_cnt = 32'h0;
`endif

endmodule
